// File: rtl/vga_sig_pkg.sv
// Shared types and CRC-32 constants for the VGA frame signature unit.
// Polynomial is the non-reflected IEEE 802.3 form, seeded with all-ones.
package vga_sig_pkg;

    typedef enum logic [0:0] {
        S_SIG_SYNC  = 1'b0,
        S_SIG_ACCUM = 1'b1
    } sig_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_parallel.sv
// Combinational CRC-32 advance over one DATA_WIDTH-bit word, MSB first.
// The loop unrolls into a single-cycle XOR network.
module crc32_parallel
    import vga_sig_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic [31:0]           crc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [31:0]           crc_o
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_i;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (crc_work[31] ^ data_i[i]) begin
                crc_work = {crc_work[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc_work = {crc_work[30:0], 1'b0};
            end
        end
    end

    assign crc_o = crc_work;

endmodule

// File: rtl/vga_frame_signature.sv
// Reduces the view window of each VGA frame to a CRC-32 and pixel count.
// Define SIG_COMPARE_EN to build the golden-signature mismatch counter.
module vga_frame_signature
    import vga_sig_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int CH_WIDTH    = 8,
    parameter int COORD_WIDTH = 10,
    parameter int WIN_LEFT    = 160,
    parameter int WIN_TOP     = 120,
    parameter int WIN_WIDTH   = 320,
    parameter int WIN_HEIGHT  = 240,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         Clock_50,
    input  logic                         Reset,
    input  logic                         pixel_en_i,
    input  logic [COORD_WIDTH-1:0]       pixel_X_pos_i,
    input  logic [COORD_WIDTH-1:0]       pixel_Y_pos_i,
    input  logic                         vsync_i,
    input  logic [CHANNELS*CH_WIDTH-1:0] pixel_data_i,
    input  logic [31:0]                  expected_sig_i,
    input  logic                         clear_i,
    output logic [31:0]                  signature_o,
    output logic [31:0]                  pixel_count_o,
    output logic                         sig_valid_o,
    output logic                         short_frame_o,
    output logic [CNT_WIDTH-1:0]         frame_count_o,
    output logic [CNT_WIDTH-1:0]         mismatch_count_o
);

    localparam int          DATA_W     = CHANNELS * CH_WIDTH;
    localparam logic [31:0] X_LO       = 32'(WIN_LEFT);
    localparam logic [31:0] X_HI       = 32'(WIN_LEFT + WIN_WIDTH);
    localparam logic [31:0] Y_LO       = 32'(WIN_TOP);
    localparam logic [31:0] Y_HI       = 32'(WIN_TOP + WIN_HEIGHT);
    localparam logic [31:0] WIN_PIXELS = 32'(WIN_WIDTH * WIN_HEIGHT);

    sig_state_t           state_q, state_d;
    logic                 vsync_q, vsync_d;
    logic [31:0]          crc_q, crc_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          signature_q, signature_d;
    logic [31:0]          pixel_count_q, pixel_count_d;
    logic                 sig_valid_q, sig_valid_d;
    logic                 short_frame_q, short_frame_d;
    logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic [31:0] crc_next;
    logic [31:0] x_ext, y_ext;
    logic        vsync_rise, vsync_fall, in_window, accept;

    crc32_parallel #(
        .DATA_WIDTH(DATA_W)
    ) u_crc (
        .crc_i (crc_q),
        .data_i(pixel_data_i),
        .crc_o (crc_next)
    );

    assign x_ext      = 32'(pixel_X_pos_i);
    assign y_ext      = 32'(pixel_Y_pos_i);
    assign vsync_rise = vsync_i & ~vsync_q;
    assign vsync_fall = ~vsync_i & vsync_q;
    assign in_window  = (x_ext >= X_LO) && (x_ext < X_HI) &&
                        (y_ext >= Y_LO) && (y_ext < Y_HI);
    assign accept     = pixel_en_i & vsync_i & ~vsync_fall & in_window;
    assign vsync_d    = vsync_i;

`ifdef SIG_COMPARE_EN
    logic [CNT_WIDTH-1:0] mismatch_q, mismatch_d;

    // The signature being loaded this cycle (crc_q) is what gets compared.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == S_SIG_ACCUM && vsync_fall &&
            crc_q != expected_sig_i && mismatch_q != {CNT_WIDTH{1'b1}}) begin
            mismatch_d = mismatch_q + 1'b1;
        end
        if (clear_i) begin
            mismatch_d = '0;
        end
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            mismatch_q <= '0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch_count_o = mismatch_q;
`else
    logic unused_expected_sig;
    assign unused_expected_sig = ^expected_sig_i;
    assign mismatch_count_o    = '0;
`endif

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        count_d       = count_q;
        signature_d   = signature_q;
        pixel_count_d = pixel_count_q;
        sig_valid_d   = 1'b0;
        short_frame_d = short_frame_q;
        frame_count_d = frame_count_q;

        case (state_q)
            S_SIG_SYNC: begin
                if (vsync_rise) begin
                    state_d = S_SIG_ACCUM;
                    crc_d   = CRC32_INIT;
                    count_d = '0;
                end
            end
            S_SIG_ACCUM: begin
                if (vsync_fall) begin
                    state_d       = S_SIG_SYNC;
                    signature_d   = crc_q;
                    pixel_count_d = count_q;
                    sig_valid_d   = 1'b1;
                    short_frame_d = (count_q != WIN_PIXELS);
                    frame_count_d = frame_count_q + 1'b1;
                end else if (accept) begin
                    crc_d = crc_next;
                    if (count_q != 32'hFFFFFFFF) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_SIG_SYNC;
            end
        endcase

        // Clear overrides the end-of-frame counter update, not the signature.
        if (clear_i) begin
            frame_count_d = '0;
            short_frame_d = 1'b0;
        end
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_SIG_SYNC;
            vsync_q       <= 1'b1;
            crc_q         <= CRC32_INIT;
            count_q       <= '0;
            signature_q   <= CRC32_INIT;
            pixel_count_q <= '0;
            sig_valid_q   <= 1'b0;
            short_frame_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            crc_q         <= crc_d;
            count_q       <= count_d;
            signature_q   <= signature_d;
            pixel_count_q <= pixel_count_d;
            sig_valid_q   <= sig_valid_d;
            short_frame_q <= short_frame_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign signature_o   = signature_q;
    assign pixel_count_o = pixel_count_q;
    assign sig_valid_o   = sig_valid_q;
    assign short_frame_o = short_frame_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_vga_frame_signature.sv
// Randomised and directed bench for vga_frame_signature with a queue-based frame model.
module tb_vga_frame_signature;

    localparam int CHANNELS    = 3;
    localparam int CH_WIDTH    = 8;
    localparam int COORD_WIDTH = 10;
    localparam int WIN_LEFT    = 0;
    localparam int WIN_TOP     = 0;
    localparam int WIN_WIDTH   = 4;
    localparam int WIN_HEIGHT  = 2;
    localparam int CNT_WIDTH   = 2;
    localparam int DW          = CHANNELS * CH_WIDTH;
    localparam int CNT_MOD     = 1 << CNT_WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   pixel_en = 1'b0;
    logic [COORD_WIDTH-1:0] px = '0;
    logic [COORD_WIDTH-1:0] py = '0;
    logic                   vsync = 1'b0;
    logic [DW-1:0]          pdata = '0;
    logic [31:0]            expected_sig = '0;
    logic                   clear = 1'b0;
    logic [31:0]            signature;
    logic [31:0]            pixel_count;
    logic                   sig_valid;
    logic                   short_frame;
    logic [CNT_WIDTH-1:0]   frame_count;
    logic [CNT_WIDTH-1:0]   mismatch_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state: the accepted pixels of the open frame are kept verbatim.
    bit          m_in_frame;
    bit          m_vs_prev;
    logic [DW-1:0] m_pix[$];
    logic [31:0] m_sig;
    logic [31:0] m_cnt;
    bit          m_valid;
    bit          m_short;
    int          m_fc;
    int          m_mm;

    vga_frame_signature #(
        .CHANNELS   (CHANNELS),
        .CH_WIDTH   (CH_WIDTH),
        .COORD_WIDTH(COORD_WIDTH),
        .WIN_LEFT   (WIN_LEFT),
        .WIN_TOP    (WIN_TOP),
        .WIN_WIDTH  (WIN_WIDTH),
        .WIN_HEIGHT (WIN_HEIGHT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .Clock_50        (clk),
        .Reset           (rst),
        .pixel_en_i      (pixel_en),
        .pixel_X_pos_i   (px),
        .pixel_Y_pos_i   (py),
        .vsync_i         (vsync),
        .pixel_data_i    (pdata),
        .expected_sig_i  (expected_sig),
        .clear_i         (clear),
        .signature_o     (signature),
        .pixel_count_o   (pixel_count),
        .sig_valid_o     (sig_valid),
        .short_frame_o   (short_frame),
        .frame_count_o   (frame_count),
        .mismatch_count_o(mismatch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] refCrc(input logic [DW-1:0] words[$]);
        logic [31:0] c;
        logic        top;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < words.size(); i++) begin
            for (int b = DW - 1; b >= 0; b--) begin
                top = c[31] ^ words[i][b];
                c   = {c[30:0], 1'b0};
                if (top) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_in_frame = 1'b0;
        m_vs_prev  = 1'b1;
        m_pix.delete();
        m_sig      = 32'hFFFFFFFF;
        m_cnt      = 32'd0;
        m_valid    = 1'b0;
        m_short    = 1'b0;
        m_fc       = 0;
        m_mm       = 0;
    endtask

    task automatic modelStep();
        bit rise, fall, inwin;
        rise    = vsync && !m_vs_prev;
        fall    = !vsync && m_vs_prev;
        inwin   = (int'(px) >= WIN_LEFT) && (int'(px) < WIN_LEFT + WIN_WIDTH) &&
                  (int'(py) >= WIN_TOP) && (int'(py) < WIN_TOP + WIN_HEIGHT);
        m_valid = 1'b0;
        if (!m_in_frame) begin
            if (rise) begin
                m_in_frame = 1'b1;
                m_pix.delete();
            end
        end else if (fall) begin
            m_in_frame = 1'b0;
            m_sig      = refCrc(m_pix);
            m_cnt      = 32'(m_pix.size());
            m_valid    = 1'b1;
            m_short    = (m_pix.size() != WIN_WIDTH * WIN_HEIGHT);
            m_fc       = (m_fc + 1) % CNT_MOD;
`ifdef SIG_COMPARE_EN
            if (m_sig != expected_sig && m_mm < CNT_MOD - 1) m_mm++;
`endif
        end else if (pixel_en && vsync && inwin) begin
            m_pix.push_back(pdata);
        end
        if (clear) begin
            m_fc    = 0;
            m_mm    = 0;
            m_short = 1'b0;
        end
        m_vs_prev = vsync;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) modelReset();
            else modelStep();
        end
    end

    // Every cycle out of reset, all outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && cmp_en) begin
                checkOutput("sig_valid", 32'(sig_valid), 32'(m_valid));
                checkOutput("signature", signature, m_sig);
                checkOutput("pixel_count", pixel_count, m_cnt);
                checkOutput("short_frame", 32'(short_frame), 32'(m_short));
                checkOutput("frame_count", 32'(frame_count), 32'(m_fc));
                checkOutput("mismatch_count", 32'(mismatch_count), 32'(m_mm));
            end
        end
    end

    // Drive one cycle of inputs at a negedge and return at the next negedge.
    task automatic applyStimulus(input bit en, input int x, input int y,
                                 input logic [DW-1:0] d, input bit vs, input bit clr);
        pixel_en = en;
        px       = COORD_WIDTH'(x);
        py       = COORD_WIDTH'(y);
        pdata    = d;
        vsync    = vs;
        clear    = clr;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3),
                          DW'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic emptyFrame();
        idleCycles(1);
        applyStimulus(1'b0, 0, 0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b0);
    endtask

    logic [DW-1:0] dq[$];
    logic [DW-1:0] w;
    int            n;

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset signature", signature, 32'hFFFFFFFF);
        checkOutput("reset pixel_count", pixel_count, 32'd0);
        checkOutput("reset sig_valid", 32'(sig_valid), 32'd0);
        checkOutput("reset frame_count", 32'(frame_count), 32'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // First frame after reset, empty.
        emptyFrame();
        checkOutput("empty sig_valid", 32'(sig_valid), 32'd1);
        checkOutput("empty signature", signature, 32'hFFFFFFFF);
        checkOutput("empty count", pixel_count, 32'd0);
        checkOutput("empty short", 32'(short_frame), 32'd1);
        checkOutput("empty frame_count", 32'(frame_count), 32'd1);
        idleCycles(1);
        checkOutput("pulse width", 32'(sig_valid), 32'd0);

        // "123456789" as three RGB words: the CRC-32/MPEG-2 check value.
        applyStimulus(1'b0, 0, 0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 0, 24'h313233, 1'b1, 1'b0);
        applyStimulus(1'b1, 1, 0, 24'h343536, 1'b1, 1'b0);
        applyStimulus(1'b1, 2, 0, 24'h373839, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b0);
        checkOutput("check-value signature", signature, 32'h0376E6E7);
        checkOutput("check-value count", pixel_count, 32'd3);

        // Full window plus out-of-window pixels, pixel strobe on the falling-edge cycle.
        idleCycles(2);
        dq.delete();
        applyStimulus(1'b1, 0, 0, DW'($urandom), 1'b1, 1'b0);
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                w = DW'($urandom);
                dq.push_back(w);
                applyStimulus(1'b1, x, y, w, 1'b1, 1'b0);
            end
        end
        for (int x = 4; x < 8; x++) applyStimulus(1'b1, x, 0, DW'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b1, 1, 1, DW'($urandom), 1'b0, 1'b0);
        checkOutput("full count", pixel_count, 32'd8);
        checkOutput("full short", 32'(short_frame), 32'd0);
        checkOutput("full signature", signature, refCrc(dq));

        // Clear coinciding with end of frame.
        idleCycles(1);
        applyStimulus(1'b0, 0, 0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 3, 1, 24'hABCDEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b1);
        checkOutput("clear frame_count", 32'(frame_count), 32'd0);
        checkOutput("clear mismatch", 32'(mismatch_count), 32'd0);
        checkOutput("clear sig_valid", 32'(sig_valid), 32'd1);
        checkOutput("clear count", pixel_count, 32'd1);
        dq.delete();
        dq.push_back(24'hABCDEF);
        checkOutput("clear signature", signature, refCrc(dq));

        // Frame counter wrap and saturating mismatch counter.
        doReset();
        for (int f = 0; f < 5; f++) begin
            expected_sig = (f == 0) ? 32'hFFFFFFFF : 32'h0;
            emptyFrame();
            checkOutput("wrap frame_count", 32'(frame_count), 32'((f + 1) % 4));
`ifdef SIG_COMPARE_EN
            checkOutput("saturating mismatch", 32'(mismatch_count), (f < 4) ? 32'(f) : 32'd3);
`else
            checkOutput("mismatch tied off", 32'(mismatch_count), 32'd0);
`endif
        end

        // Reset in the middle of a frame discards it.
        doReset();
        idleCycles(1);
        applyStimulus(1'b0, 0, 0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 0, DW'($urandom), 1'b1, 1'b0);
        doReset();
        applyStimulus(1'b1, 0, 1, DW'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b0);
        checkOutput("midreset no valid", 32'(sig_valid), 32'd0);
        checkOutput("midreset frame_count", 32'(frame_count), 32'd0);
        applyStimulus(1'b0, 0, 0, '0, 1'b1, 1'b0);
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) applyStimulus(1'b1, x, y, DW'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, '0, 1'b0, 1'b0);
        checkOutput("post-reset count", pixel_count, 32'd8);
        checkOutput("post-reset valid", 32'(sig_valid), 32'd1);

        // Random frames with strobes during edges, stray coordinates and clears.
        for (int f = 0; f < 40; f++) begin
            idleCycles($urandom_range(1, 3));
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1),
                          DW'($urandom), 1'b1, 1'b0);
            n = $urandom_range(0, 14);
            for (int i = 0; i < n; i++) begin
                applyStimulus(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 3),
                              DW'($urandom), 1'b1, 1'($urandom_range(0, 15) == 0));
            end
            expected_sig = ($urandom_range(0, 1) == 1) ? refCrc(m_pix) : $urandom;
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1),
                          DW'($urandom), 1'b0, 1'($urandom_range(0, 7) == 0));
        end
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
